// File: rtl/data_mem_pkg.sv
// Shared definitions for the data memory bank: FSM state encoding and the
// width of the wait-cycle down-counter.
package data_mem_pkg;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        BUSY = 2'd1,
        RESP = 2'd2
    } state_e;

    localparam int WAIT_CNT_W = 4;

endpackage

// File: rtl/data_mem_array.sv
// Word storage for the data memory bank: asynchronous read, byte-masked write.
// Per-byte strobes are honoured only when DATA_MEM_BYTE_STROBE_EN is defined.
module data_mem_array #(
    parameter int DATA_W = 32,
    parameter int DEPTH  = 65536,
    parameter int IDX_W  = 16
) (
    input  logic                  clk,
    input  logic                  we,
    input  logic [IDX_W-1:0]      idx,
    input  logic [DATA_W-1:0]     wdata,
    input  logic [DATA_W/8-1:0]   be,
    output logic [DATA_W-1:0]     rdata
);
    localparam int BYTES = DATA_W / 8;

    logic [DATA_W-1:0] mem [DEPTH];
    logic [BYTES-1:0]  byteEn;

`ifdef DATA_MEM_BYTE_STROBE_EN
    assign byteEn = be;
`else
    // Full-word writes only; the strobes are deliberately left unconnected.
    assign byteEn = '1;
    logic unused_be;
    assign unused_be = ^be;
`endif

    always_ff @(posedge clk) begin
        if (we) begin
            for (int i = 0; i < BYTES; i++) begin
                if (byteEn[i]) begin
                    mem[idx][8*i +: 8] <= wdata[8*i +: 8];
                end
            end
        end
    end

    assign rdata = mem[idx];

endmodule

// File: rtl/data_mem_bank.sv
// Byte-addressed data memory bank with single-request handshake and a fixed
// WAIT-cycle response latency. Define DATA_MEM_BYTE_STROBE_EN for byte strobes.
module data_mem_bank
    import data_mem_pkg::*;
#(
    parameter int DATA_W    = 32,
    parameter int DEPTH     = 65536,
    parameter int ADDR_W    = 32,
    parameter int BASE_ADDR = 1024,
    parameter int WAIT      = 1
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic                  req,
    input  logic                  we,
    input  logic [ADDR_W-1:0]     addr,
    input  logic [DATA_W-1:0]     wdata,
    input  logic [DATA_W/8-1:0]   be,
    output logic                  ready,
    output logic                  resp_valid,
    output logic [DATA_W-1:0]     rdata,
    output logic                  err
);
    localparam int BYTES = DATA_W / 8;
    localparam int OFF_W = $clog2(BYTES);
    localparam int IDX_W = (DEPTH > 1) ? $clog2(DEPTH) : 1;
    localparam logic [ADDR_W-1:0] BASE_A  = ADDR_W'(BASE_ADDR);
    localparam logic [ADDR_W:0]   DEPTH_A = (ADDR_W+1)'(DEPTH);

    state_e                state_q;
    logic [WAIT_CNT_W-1:0] waitCnt_q;
    logic                  ready_q;
    logic                  respValid_q;
    logic                  err_q;
    logic                  pendErr_q;
    logic [DATA_W-1:0]     rdata_q;
    logic [DATA_W-1:0]     pendData_q;

    logic [ADDR_W-1:0]     offset;
    logic [ADDR_W-1:0]     fullIdx;
    logic                  inRange;
    logic                  accept;
    logic                  memWe;
    logic [DATA_W-1:0]     memRdata;
    logic [DATA_W-1:0]     respData;

    // Underflow of the subtraction is harmless: addresses below the base are
    // rejected by the explicit comparison before the index is trusted.
    assign offset   = addr - BASE_A;
    assign fullIdx  = offset >> OFF_W;
    assign inRange  = (addr >= BASE_A) && ({1'b0, fullIdx} < DEPTH_A);
    assign accept   = req && (state_q == IDLE);
    assign memWe    = accept && we && inRange;
    assign respData = (inRange && !we) ? memRdata : '0;

    data_mem_array #(
        .DATA_W (DATA_W),
        .DEPTH  (DEPTH),
        .IDX_W  (IDX_W)
    ) u_array (
        .clk    (clk),
        .we     (memWe),
        .idx    (fullIdx[IDX_W-1:0]),
        .wdata  (wdata),
        .be     (be),
        .rdata  (memRdata)
    );

    // With WAIT == 0 the response registers load straight from the array on
    // the accepting edge; otherwise the result waits in the pending registers.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state_q     <= IDLE;
            waitCnt_q   <= '0;
            ready_q     <= 1'b1;
            respValid_q <= 1'b0;
            rdata_q     <= '0;
            err_q       <= 1'b0;
            pendData_q  <= '0;
            pendErr_q   <= 1'b0;
        end else begin
            respValid_q <= 1'b0;
            case (state_q)
                IDLE: begin
                    if (accept) begin
                        ready_q <= 1'b0;
                        if (WAIT == 0) begin
                            state_q     <= RESP;
                            respValid_q <= 1'b1;
                            rdata_q     <= respData;
                            err_q       <= !inRange;
                        end else begin
                            state_q    <= BUSY;
                            waitCnt_q  <= WAIT_CNT_W'(WAIT - 1);
                            pendData_q <= respData;
                            pendErr_q  <= !inRange;
                        end
                    end
                end
                BUSY: begin
                    if (waitCnt_q == '0) begin
                        state_q     <= RESP;
                        respValid_q <= 1'b1;
                        rdata_q     <= pendData_q;
                        err_q       <= pendErr_q;
                    end else begin
                        waitCnt_q <= waitCnt_q - 1'b1;
                    end
                end
                RESP: begin
                    state_q <= IDLE;
                    ready_q <= 1'b1;
                end
                default: begin
                    state_q <= IDLE;
                    ready_q <= 1'b1;
                end
            endcase
        end
    end

    assign ready      = ready_q;
    assign resp_valid = respValid_q;
    assign rdata      = rdata_q;
    assign err        = err_q;

endmodule

// File: tb/tb_data_mem_bank.sv
// Bench for data_mem_bank: three instances (WAIT = 0, 1, 2) share the request
// buses, each checked every cycle against a cycle-stamped behavioural model.
module tb_data_mem_bank;

    localparam int NDUT  = 3;
    localparam int DEPTH = 16;
    localparam int BASE  = 1024;
`ifdef DATA_MEM_BYTE_STROBE_EN
    localparam bit STROBE_EN = 1'b1;
`else
    localparam bit STROBE_EN = 1'b0;
`endif

    logic            clk = 1'b0;
    logic            rst = 1'b0;
    logic [NDUT-1:0] reqV = '0;
    logic            we = 1'b0;
    logic [31:0]     addr = '0;
    logic [31:0]     wdata = '0;
    logic [3:0]      be = '0;
    logic [NDUT-1:0] readyV;
    logic [NDUT-1:0] rvV;
    logic [NDUT-1:0] errV;
    logic [31:0]     rdataV [NDUT];

    int tests = 0;
    int fails = 0;

    always #5 clk = ~clk;

    for (genvar g = 0; g < NDUT; g++) begin : g_dut
        data_mem_bank #(
            .DATA_W    (32),
            .DEPTH     (DEPTH),
            .ADDR_W    (32),
            .BASE_ADDR (BASE),
            .WAIT      (g)
        ) u_dut (
            .clk        (clk),
            .rst        (rst),
            .req        (reqV[g]),
            .we         (we),
            .addr       (addr),
            .wdata      (wdata),
            .be         (be),
            .ready      (readyV[g]),
            .resp_valid (rvV[g]),
            .rdata      (rdataV[g]),
            .err        (errV[g])
        );
    end

    // Model state: instance k has WAIT = k, so a request accepted on edge c
    // responds on edge c+k and the instance accepts again from edge c+k+2.
    int          cyc = 0;
    int          freeAt [NDUT];
    int          respAt [NDUT];
    bit          pend [NDUT];
    logic [31:0] pendData [NDUT];
    bit          pendErr [NDUT];
    logic [31:0] holdData [NDUT];
    bit          holdErr [NDUT];
    bit          expReady [NDUT];
    bit          expRv [NDUT];
    logic [31:0] mem [NDUT][DEPTH];

    // Observations of the DUTs used by the directed literal checks.
    bit          readySeen [NDUT];
    int          accCount [NDUT];
    int          respCount [NDUT];
    int          lastAccCyc [NDUT];
    int          lastRespCyc [NDUT];
    logic [31:0] lastRdata [NDUT];
    bit          lastErr [NDUT];
    bit          lastRespReady [NDUT];
    int          accLog2 [$];

    function automatic bit modelRange(input logic [31:0] a, output int idx);
        longint off;
        off = longint'(a) - longint'(BASE);
        idx = 0;
        if (off < 0) return 1'b0;
        if ((off >> 2) >= longint'(DEPTH)) return 1'b0;
        idx = int'(off >> 2);
        return 1'b1;
    endfunction

    function automatic logic [31:0] maskedWrite(input logic [31:0] oldv, input logic [31:0] newv,
                                                input logic [3:0] b);
        logic [3:0]  m;
        logic [31:0] r;
        m = STROBE_EN ? b : 4'hF;
        r = oldv;
        for (int i = 0; i < 4; i++) if (m[i]) r[8*i +: 8] = newv[8*i +: 8];
        return r;
    endfunction

    task automatic checkOutput(input string name, input int k, input logic [31:0] got,
                               input logic [31:0] want);
        tests++;
        if (got !== want) begin
            fails++;
            $display("[TB] FAIL %s dut%0d cyc=%0d got=%h want=%h", name, k, cyc, got, want);
        end
    endtask

    always @(posedge clk) begin
        bit inr;
        int idx;
        cyc++;
        for (int k = 0; k < NDUT; k++) begin
            if (!rst) begin
                freeAt[k]   = cyc + 1;
                pend[k]     = 1'b0;
                holdData[k] = '0;
                holdErr[k]  = 1'b0;
                expReady[k] = 1'b1;
                expRv[k]    = 1'b0;
            end else begin
                if (reqV[k] && readySeen[k]) begin
                    accCount[k]++;
                    lastAccCyc[k] = cyc;
                    if (k == 2) accLog2.push_back(cyc);
                end
                if (reqV[k] && cyc >= freeAt[k]) begin
                    inr = modelRange(addr, idx);
                    if (we) begin
                        if (inr) mem[k][idx] = maskedWrite(mem[k][idx], wdata, be);
                        pendData[k] = '0;
                    end else begin
                        pendData[k] = inr ? mem[k][idx] : 32'h0;
                    end
                    pendErr[k] = !inr;
                    pend[k]    = 1'b1;
                    respAt[k]  = cyc + k;
                    freeAt[k]  = cyc + k + 2;
                end
                expRv[k] = 1'b0;
                if (pend[k] && cyc == respAt[k]) begin
                    expRv[k]    = 1'b1;
                    holdData[k] = pendData[k];
                    holdErr[k]  = pendErr[k];
                    pend[k]     = 1'b0;
                end
                expReady[k] = (cyc + 1 >= freeAt[k]);
            end
        end
    end

    always @(posedge clk) begin
        #2;
        for (int k = 0; k < NDUT; k++) begin
            readySeen[k] = readyV[k];
            checkOutput("ready", k, 32'(readyV[k]), 32'(expReady[k]));
            checkOutput("resp_valid", k, 32'(rvV[k]), 32'(expRv[k]));
            checkOutput("rdata", k, rdataV[k], holdData[k]);
            checkOutput("err", k, 32'(errV[k]), 32'(holdErr[k]));
            if (rvV[k]) begin
                respCount[k]++;
                lastRespCyc[k]   = cyc;
                lastRdata[k]     = rdataV[k];
                lastErr[k]       = errV[k];
                lastRespReady[k] = readyV[k];
            end
        end
    end

    // Holds the request on each selected instance until it is accepted, then
    // waits (bounded) for every selected instance to respond.
    task automatic applyStimulus(input logic [NDUT-1:0] mask, input logic w, input logic [31:0] a,
                                 input logic [31:0] d, input logic [3:0] b);
        int  startAcc [NDUT];
        int  startResp [NDUT];
        int  budget;
        bit  done;
        @(negedge clk);
        we = w; addr = a; wdata = d; be = b; reqV = mask;
        for (int k = 0; k < NDUT; k++) begin
            startAcc[k]  = accCount[k];
            startResp[k] = respCount[k];
        end
        budget = 0;
        done   = 1'b0;
        while (!done && budget < 50) begin
            @(negedge clk);
            budget++;
            done = 1'b1;
            for (int k = 0; k < NDUT; k++) begin
                if (accCount[k] != startAcc[k]) reqV[k] = 1'b0;
                if (mask[k] && respCount[k] == startResp[k]) done = 1'b0;
            end
        end
        reqV = '0;
        if (!done) begin
            tests++;
            fails++;
            $display("[TB] FAIL handshake_timeout addr=%h got=no_response want=response", a);
        end
    endtask

    initial begin
        #200000;
        $display("[TB] FAIL global_timeout got=running want=finished");
        $fatal(1, "[TB] timeout");
    end

    initial begin
        repeat (3) @(negedge clk);
        for (int k = 0; k < NDUT; k++) begin
            checkOutput("reset_ready", k, 32'(readyV[k]), 32'd1);
            checkOutput("reset_resp_valid", k, 32'(rvV[k]), 32'd0);
            checkOutput("reset_rdata", k, rdataV[k], 32'h0);
        end
        rst = 1'b1;

        for (int i = 0; i < DEPTH; i++) applyStimulus(3'b111, 1'b1, 32'(BASE + 4*i), $urandom, 4'hF);

        applyStimulus(3'b111, 1'b1, 32'd1028, 32'hDEADBEEF, 4'hF);
        checkOutput("wr_latency", 1, 32'(lastRespCyc[1] - lastAccCyc[1] + 1), 32'd2);
        checkOutput("wr_err", 1, 32'(lastErr[1]), 32'd0);
        applyStimulus(3'b111, 1'b0, 32'd1028, 32'h0, 4'hF);
        checkOutput("rd_latency", 1, 32'(lastRespCyc[1] - lastAccCyc[1] + 1), 32'd2);
        checkOutput("rd_latency", 2, 32'(lastRespCyc[2] - lastAccCyc[2] + 1), 32'd3);
        for (int k = 0; k < NDUT; k++) begin
            checkOutput("rd_deadbeef", k, lastRdata[k], 32'hDEADBEEF);
            checkOutput("rd_err", k, 32'(lastErr[k]), 32'd0);
        end

        applyStimulus(3'b111, 1'b1, 32'd1032, 32'h11223344, 4'hF);
        applyStimulus(3'b111, 1'b1, 32'd1032, 32'hAABBCCDD, 4'b0101);
        applyStimulus(3'b111, 1'b0, 32'd1032, 32'h0, 4'hF);
        checkOutput("byte_strobe", 1, lastRdata[1], STROBE_EN ? 32'h11BB33DD : 32'hAABBCCDD);

        // Reset while instance 2 is still counting down after accepting a write.
        @(negedge clk);
        we = 1'b1; addr = 32'd1036; wdata = 32'h5A5A5A5A; be = 4'hF; reqV = 3'b100;
        @(negedge clk);
        reqV = '0;
        rst  = 1'b0;
        @(posedge clk);
        #3;
        checkOutput("midbusy_rst_ready", 2, 32'(readyV[2]), 32'd1);
        checkOutput("midbusy_rst_resp_valid", 2, 32'(rvV[2]), 32'd0);
        checkOutput("midbusy_rst_rdata", 2, rdataV[2], 32'h0);
        checkOutput("midbusy_rst_err", 2, 32'(errV[2]), 32'd0);
        @(negedge clk);
        rst = 1'b1;
        applyStimulus(3'b100, 1'b0, 32'd1036, 32'h0, 4'hF);
        checkOutput("committed_before_rst", 2, lastRdata[2], 32'h5A5A5A5A);

        applyStimulus(3'b111, 1'b0, 32'd1020, 32'h0, 4'hF);
        checkOutput("below_base_err", 1, 32'(lastErr[1]), 32'd1);
        checkOutput("below_base_rdata", 1, lastRdata[1], 32'h0);
        applyStimulus(3'b111, 1'b0, 32'(BASE + 4*DEPTH), 32'h0, 4'hF);
        checkOutput("past_end_err", 1, 32'(lastErr[1]), 32'd1);
        checkOutput("past_end_rdata", 1, lastRdata[1], 32'h0);
        applyStimulus(3'b111, 1'b1, 32'd1020, 32'hFFFFFFFF, 4'hF);
        checkOutput("oor_write_err", 0, 32'(lastErr[0]), 32'd1);
        for (int i = 0; i < DEPTH; i++) applyStimulus(3'b111, 1'b0, 32'(BASE + 4*i), 32'h0, 4'hF);
        applyStimulus(3'b111, 1'b0, 32'd1028, 32'h0, 4'hF);
        checkOutput("oor_write_kept", 1, lastRdata[1], 32'hDEADBEEF);

        applyStimulus(3'b001, 1'b1, 32'd1024, 32'h0BADF00D, 4'hF);
        applyStimulus(3'b001, 1'b0, 32'd1027, 32'h0, 4'hF);
        checkOutput("aligned_down", 0, lastRdata[0], 32'h0BADF00D);
        checkOutput("wait0_latency", 0, 32'(lastRespCyc[0] - lastAccCyc[0] + 1), 32'd1);
        checkOutput("wait0_ready_in_resp", 0, 32'(lastRespReady[0]), 32'd0);

        @(negedge clk);
        accLog2.delete();
        we = 1'b0; addr = 32'd1028; be = 4'hF; reqV = 3'b100;
        repeat (12) @(negedge clk);
        reqV = '0;
        repeat (4) @(negedge clk);
        checkOutput("bp_accepts", 2, 32'(accLog2.size()), 32'd3);
        if (accLog2.size() == 3) begin
            checkOutput("bp_gap1", 2, 32'(accLog2[1] - accLog2[0]), 32'd4);
            checkOutput("bp_gap2", 2, 32'(accLog2[2] - accLog2[1]), 32'd4);
        end

        for (int n = 0; n < 600; n++) begin
            @(negedge clk);
            reqV  = NDUT'($urandom);
            we    = 1'($urandom);
            addr  = ($urandom_range(0, 7) == 0) ? $urandom
                                                : 32'(BASE - 4 + $urandom_range(0, 4*DEPTH + 7));
            wdata = $urandom;
            be    = 4'($urandom);
            rst   = (n == 300) ? 1'b0 : 1'b1;
        end
        @(negedge clk);
        reqV = '0;
        rst  = 1'b1;
        repeat (8) @(negedge clk);

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule
